regfile_writeback_unit: RTL and testbench

//  Write side of the integer register file. Merges two writeback sources into the single
//  RF write port: single-cycle ALU results and valid/ready LSU load results. LSU results
//  are buffered in a FIFO. A scoreboard marks destinations with an outstanding load, which

---
 rtl/riscv_pkg.sv | 12 +
 rtl/regfile_writeback_unit_if.sv | 57 +++++
 rtl/wb_fifo.sv | 55 +++++
 rtl/regfile_writeback_unit.sv | 116 +++++++++++
 tb/tb_regfile_writeback_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-core types: architectural widths and the writeback request record.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Bundle between decode/execute/LSU and the writeback unit; the unit is the slave.
// Optional forwarding signals exist only when WB_BYPASS_EN is defined.
interface regfile_writeback_unit_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int LSU_FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;

    logic                  issue_valid;
    logic                  issue_ready;
    logic [ADDR_WIDTH-1:0] issue_rd_addr;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  alu_wb_valid;
    logic [ADDR_WIDTH-1:0] alu_wb_addr;
    logic [DATA_WIDTH-1:0] alu_wb_data;
    logic                  lsu_wb_valid;
    logic                  lsu_wb_ready;
    logic [ADDR_WIDTH-1:0] lsu_wb_addr;
    logic [DATA_WIDTH-1:0] lsu_wb_data;
    logic                  rf_wr_en;
    logic [ADDR_WIDTH-1:0] rf_rd_addr;
    logic [DATA_WIDTH-1:0] rf_rd_data;
    logic [CNT_W-1:0]      lsu_fifo_count;
`ifdef WB_BYPASS_EN
    logic                  rs1_fwd_valid;
    logic [DATA_WIDTH-1:0] rs1_fwd_data;
    logic                  rs2_fwd_valid;
    logic [DATA_WIDTH-1:0] rs2_fwd_data;
`endif

    modport master (
        output issue_valid, issue_rd_addr, rs1_addr, rs2_addr,
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        input  issue_ready, rs1_busy, rs2_busy, lsu_wb_ready,
        input  rf_wr_en, rf_rd_addr, rf_rd_data, lsu_fifo_count
`ifdef WB_BYPASS_EN
        , input rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
    );

    modport slave (
        input  issue_valid, issue_rd_addr, rs1_addr, rs2_addr,
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        output issue_ready, rs1_busy, rs2_busy, lsu_wb_ready,
        output rf_wr_en, rf_rd_addr, rf_rd_data, lsu_fifo_count
`ifdef WB_BYPASS_EN
        , output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO for writeback requests; head entry is visible combinationally
// so the consumer's own output register provides the read stage.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter type entry_t = wb_req_t,
    parameter int  DEPTH   = 4,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem_reg[rd_ptr_reg];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap without compare logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/regfile_writeback_unit.sv
// Merges ALU results and buffered LSU loads onto the single RF write port and keeps
// the load scoreboard. Define WB_BYPASS_EN to add same-cycle write forwarding outputs.
module regfile_writeback_unit
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH     = XLEN,
    parameter int ADDR_WIDTH     = REG_ADDR_W,
    parameter int LSU_FIFO_DEPTH = 4
) (
    input logic                      clk,
    input logic                      reset,
    regfile_writeback_unit_if.slave  bus
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } lsu_entry_t;

    logic [NUM_REGS-1:0]   sb_reg;
    logic [NUM_REGS-1:0]   sb_next;
    lsu_entry_t            push_entry;
    lsu_entry_t            head_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  lsu_push;
    logic                  lsu_pop;
    logic                  issue_fire;
    logic                  rf_wr_en_reg;
    logic [ADDR_WIDTH-1:0] rf_rd_addr_reg;
    logic [DATA_WIDTH-1:0] rf_rd_data_reg;

    assign push_entry = {bus.lsu_wb_addr, bus.lsu_wb_data};
    assign lsu_push   = bus.lsu_wb_valid & ~fifo_full;
    assign lsu_pop    = ~bus.alu_wb_valid & ~fifo_empty;
    assign issue_fire = bus.issue_valid & bus.issue_ready;

    assign bus.lsu_wb_ready = ~fifo_full;
    assign bus.issue_ready  = ~sb_reg[bus.issue_rd_addr] | (bus.issue_rd_addr == '0);
    assign bus.rs1_busy     = sb_reg[bus.rs1_addr] & (bus.rs1_addr != '0);
    assign bus.rs2_busy     = sb_reg[bus.rs2_addr] & (bus.rs2_addr != '0);

    wb_fifo #(
        .entry_t (lsu_entry_t),
        .DEPTH   (LSU_FIFO_DEPTH)
    ) u_lsu_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (lsu_push),
        .push_data (push_entry),
        .pop       (lsu_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (bus.lsu_fifo_count)
    );

    // A new load issued to a register whose previous load retires this cycle keeps it busy.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
        if (gi == 0) begin : g_x0
            assign sb_next[gi] = 1'b0;
        end else begin : g_xn
            always_comb begin
                sb_next[gi] = sb_reg[gi];
                if (lsu_pop && head_entry.addr == ADDR_WIDTH'(gi)) sb_next[gi] = 1'b0;
                if (issue_fire && bus.issue_rd_addr == ADDR_WIDTH'(gi)) sb_next[gi] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_reg <= '0;
        end else begin
            sb_reg <= sb_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_wr_en_reg   <= 1'b0;
            rf_rd_addr_reg <= '0;
            rf_rd_data_reg <= '0;
        end else if (bus.alu_wb_valid) begin
            rf_wr_en_reg   <= (bus.alu_wb_addr != '0);
            rf_rd_addr_reg <= bus.alu_wb_addr;
            rf_rd_data_reg <= bus.alu_wb_data;
        end else if (lsu_pop) begin
            rf_wr_en_reg   <= (head_entry.addr != '0);
            rf_rd_addr_reg <= head_entry.addr;
            rf_rd_data_reg <= head_entry.data;
        end else begin
            rf_wr_en_reg   <= 1'b0;
        end
    end

    assign bus.rf_wr_en   = rf_wr_en_reg;
    assign bus.rf_rd_addr = rf_rd_addr_reg;
    assign bus.rf_rd_data = rf_rd_data_reg;

`ifdef WB_BYPASS_EN
    assign bus.rs1_fwd_valid = rf_wr_en_reg & (rf_rd_addr_reg == bus.rs1_addr) & (bus.rs1_addr != '0);
    assign bus.rs1_fwd_data  = rf_rd_data_reg;
    assign bus.rs2_fwd_valid = rf_wr_en_reg & (rf_rd_addr_reg == bus.rs2_addr) & (bus.rs2_addr != '0);
    assign bus.rs2_fwd_data  = rf_rd_data_reg;
`endif

    // Decode must never let an ALU result overtake an outstanding load to the same register.
    always_ff @(posedge clk) begin
        if (!reset && bus.alu_wb_valid && bus.alu_wb_addr != '0) begin
            assert (!sb_reg[bus.alu_wb_addr]);
        end
    end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed and random stimulus against a queue/array model of the writeback unit.
module tb_regfile_writeback_unit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 4;

    typedef struct {
        int unsigned addr;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    regfile_writeback_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LSU_FIFO_DEPTH(D)) bus ();

    regfile_writeback_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LSU_FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit            sb_m [32];
    ent_t          q_m [$];
    int unsigned   pend [$];
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    bit            last_push;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.issue_valid   = 1'b0;
        bus.issue_rd_addr = '0;
        bus.rs1_addr      = '0;
        bus.rs2_addr      = '0;
        bus.alu_wb_valid  = 1'b0;
        bus.alu_wb_addr   = '0;
        bus.alu_wb_data   = '0;
        bus.lsu_wb_valid  = 1'b0;
        bus.lsu_wb_addr   = '0;
        bus.lsu_wb_data   = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) sb_m[i] = 1'b0;
        q_m.delete();
        pend.delete();
        exp_en = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, check registers after edge.
    task automatic cycle();
        int unsigned rd;
        bit ir, lr, fire;
        ent_t e;
        @(negedge clk);
        rd = bus.issue_rd_addr;
        ir = (rd == 0) || !sb_m[rd];
        lr = q_m.size() < D;
        chk("issue_ready", bus.issue_ready, ir);
        chk("rs1_busy", bus.rs1_busy, sb_m[bus.rs1_addr] && bus.rs1_addr != 0);
        chk("rs2_busy", bus.rs2_busy, sb_m[bus.rs2_addr] && bus.rs2_addr != 0);
        chk("lsu_ready", bus.lsu_wb_ready, lr);
        chk("count_pre", bus.lsu_fifo_count, q_m.size());
        fire = bus.issue_valid && ir;
        last_push = bus.lsu_wb_valid && lr;
        if (bus.alu_wb_valid) begin
            exp_en = (bus.alu_wb_addr != 0);
            exp_addr = bus.alu_wb_addr;
            exp_data = bus.alu_wb_data;
        end else if (q_m.size() > 0) begin
            e = q_m.pop_front();
            exp_en = (e.addr != 0);
            exp_addr = AW'(e.addr);
            exp_data = e.data;
            sb_m[e.addr] = 1'b0;
        end else begin
            exp_en = 1'b0;
        end
        if (last_push) begin
            e.addr = bus.lsu_wb_addr;
            e.data = bus.lsu_wb_data;
            q_m.push_back(e);
            if (pend.size() > 0 && pend[0] == bus.lsu_wb_addr) void'(pend.pop_front());
        end
        if (fire) begin
            if (rd != 0) sb_m[rd] = 1'b1;
            pend.push_back(rd);
        end
        @(posedge clk);
        #1;
        chk("rf_wr_en", bus.rf_wr_en, exp_en);
        chk("rf_rd_addr", bus.rf_rd_addr, exp_addr);
        chk("rf_rd_data", bus.rf_rd_data, exp_data);
        chk("count_post", bus.lsu_fifo_count, q_m.size());
`ifdef WB_BYPASS_EN
        chk("rs1_fwd_valid", bus.rs1_fwd_valid, exp_en && exp_addr == bus.rs1_addr && bus.rs1_addr != 0);
        chk("rs2_fwd_valid", bus.rs2_fwd_valid, exp_en && exp_addr == bus.rs2_addr && bus.rs2_addr != 0);
        if (exp_en) chk("rs1_fwd_data", bus.rs1_fwd_data, exp_data);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unsigned aa;
        drive_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr_en", bus.rf_wr_en, 1'b0);
        chk("reset_addr", bus.rf_rd_addr, 0);
        chk("reset_data", bus.rf_rd_data, 0);
        chk("reset_count", bus.lsu_fifo_count, 0);
        reset = 1'b0;

        // ALU write to x3 visible one cycle later
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd3; bus.alu_wb_data = 32'hDEAD_BEEF;
        cycle();
        chk("t2_en", bus.rf_wr_en, 1'b1);
        chk("t2_data", bus.rf_rd_data, 32'hDEAD_BEEF);
        drive_idle();

        // Load x7: busy until the load is written
        bus.issue_valid = 1'b1; bus.issue_rd_addr = 5'd7;
        cycle();
        drive_idle();
        bus.rs1_addr = 5'd7;
        cycle();
        chk("t3_busy", bus.rs1_busy, 1'b1);
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd7; bus.lsu_wb_data = 32'h1234;
        cycle();
        bus.lsu_wb_valid = 1'b0;
        cycle();
        chk("t3_wr_addr", bus.rf_rd_addr, 7);
        chk("t3_wr_data", bus.rf_rd_data, 32'h1234);
        cycle();

        // ALU saturates the port while five loads arrive
        n = 0;
        for (int k = 0; k < 6; k++) begin
            bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = AW'(10 + k); bus.alu_wb_data = 32'hA000 + k;
            bus.lsu_wb_valid = (n < 5); bus.lsu_wb_addr = AW'(20 + n); bus.lsu_wb_data = 32'hB000 + n;
            cycle();
            if (last_push) n++;
        end
        chk("t4_full_count", bus.lsu_fifo_count, 4);
        chk("t4_stall_ready", bus.lsu_wb_ready, 1'b0);
        bus.alu_wb_valid = 1'b0;
        for (int k = 0; k < 20 && (n < 5 || q_m.size() > 0); k++) begin
            bus.lsu_wb_valid = (n < 5); bus.lsu_wb_addr = AW'(20 + n); bus.lsu_wb_data = 32'hB000 + n;
            cycle();
            if (last_push) n++;
        end
        chk("t4_drained", bus.lsu_fifo_count, 0);
        drive_idle();

        // x0 writes from both sources are suppressed
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = '0; bus.lsu_wb_data = 32'h77;
        cycle();
        drive_idle();
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = '0; bus.alu_wb_data = 32'h99;
        cycle();
        chk("t5_alu_x0", bus.rf_wr_en, 1'b0);
        drive_idle();
        cycle();
        chk("t5_lsu_x0", bus.rf_wr_en, 1'b0);
        chk("t5_popped", bus.lsu_fifo_count, 0);

`ifdef WB_BYPASS_EN
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd9; bus.alu_wb_data = 32'h55;
        bus.rs2_addr = 5'd9;
        cycle();
        chk("t6_fwd_valid", bus.rs2_fwd_valid, 1'b1);
        chk("t6_fwd_data", bus.rs2_fwd_data, 32'h55);
        drive_idle();
`endif

        // Mid-stream reset with three buffered loads and x5 pending
        bus.issue_valid = 1'b1; bus.issue_rd_addr = 5'd5;
        cycle();
        drive_idle();
        for (int k = 0; k < 3; k++) begin
            bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = AW'(10 + k); bus.alu_wb_data = k;
            bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = (k == 0) ? 5'd5 : AW'(k + 5); bus.lsu_wb_data = 32'hC0 + k;
            cycle();
        end
        chk("t1_count3", bus.lsu_fifo_count, 3);
        drive_idle();
        bus.rs1_addr = 5'd5;
        @(negedge clk);
        chk("t1_busy_before", bus.rs1_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t1_count", bus.lsu_fifo_count, 0);
        chk("t1_wr_en", bus.rf_wr_en, 1'b0);
        chk("t1_sb5", bus.rs1_busy, 1'b0);
        chk("t1_ready5", bus.lsu_wb_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random traffic that respects the upstream hazard rules
        for (int i = 0; i < 400; i++) begin
            bus.issue_valid   = ($urandom_range(0, 99) < 30);
            bus.issue_rd_addr = AW'($urandom_range(0, 31));
            bus.rs1_addr      = AW'($urandom_range(0, 31));
            bus.rs2_addr      = AW'($urandom_range(0, 31));
            aa = $urandom_range(0, 31);
            bus.alu_wb_valid  = ($urandom_range(0, 99) < 40) && !sb_m[aa];
            bus.alu_wb_addr   = AW'(aa);
            bus.alu_wb_data   = $urandom;
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                bus.lsu_wb_valid = 1'b1;
                bus.lsu_wb_addr  = AW'(pend[0]);
            end else begin
                bus.lsu_wb_valid = 1'b0;
                bus.lsu_wb_addr  = '0;
            end
            bus.lsu_wb_data = $urandom;
            cycle();
        end
        drive_idle();
        for (int k = 0; k < 8; k++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
